// File: rtl/v_bus_chk.sv
// Passive checker for the v list-update / list-lookup buses: tracks per-product
// occupancy and outstanding lookups, and reports the lowest-coded error each cycle.
module v_bus_chk #(
  parameter  int N_PROD    = 4,
  parameter  int DEPTH     = 16,
  parameter  int KEY_W     = 16,
  parameter  int SIZE_W    = 16,
  parameter  int LEVEL_W   = 4,
  parameter  int MAX_OUT   = 4,
  parameter  int TIMEOUT   = 32,
  parameter  int ERR_CNT_W = 16,
  localparam int PROD_ID_W = (N_PROD > 1) ? $clog2(N_PROD) : 1,
  localparam int OCC_W     = $clog2(DEPTH + 1),
  localparam int TS_W      = $clog2(TIMEOUT) + 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_upd_vld,
  input  logic [PROD_ID_W-1:0]      i_upd_prod_id,
  input  logic [1:0]                i_upd_cmd,
  input  logic [KEY_W-1:0]          i_upd_key,
  input  logic [SIZE_W-1:0]         i_upd_size,
  input  logic                      i_lut_vld,
  input  logic [PROD_ID_W-1:0]      i_lut_prod_id,
  input  logic [LEVEL_W-1:0]        i_lut_level,
  input  logic                      i_rsp_vld,
  input  logic                      i_err_clr,
  output logic                      o_err_vld,
  output logic [3:0]                o_err_code,
  output logic [PROD_ID_W-1:0]      o_err_prod_id,
  output logic                      o_err_sticky,
  output logic [ERR_CNT_W-1:0]      o_err_cnt,
  output logic [N_PROD*OCC_W-1:0]   o_occ
);
  localparam int PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int CMP_W = (LEVEL_W > OCC_W) ? LEVEL_W : OCC_W;
  localparam logic [PROD_ID_W:0] NPROD = N_PROD[PROD_ID_W:0];

  logic [N_PROD-1:0][OCC_W-1:0] r_occ;
  logic [MAX_OUT-1:0][TS_W-1:0] r_fifo;
  logic [PTR_W-1:0]             r_rd, r_wr;
  logic [PTR_W:0]               r_cnt_out;
  logic [TS_W-1:0]              r_ts;

  logic                 w_upd_ok, w_lut_ok, w_lut_lvl_err, w_upd_err;
  logic [OCC_W-1:0]     w_upd_occ, w_lut_occ;
  logic                 w_empty, w_full, w_to, w_pop, w_push, w_ovf;
  logic [TS_W-1:0]      w_age;
  logic [8:0]           w_err;
  logic [3:0]           w_code;
  logic [PROD_ID_W-1:0] w_prod;
  logic                 w_unused_obs;

  // key and size are carried on the bus but carry no checkable state
  assign w_unused_obs = ^{i_upd_key, i_upd_size};

  assign w_upd_ok      = {1'b0, i_upd_prod_id} < NPROD;
  assign w_lut_ok      = {1'b0, i_lut_prod_id} < NPROD;
  assign w_upd_occ     = w_upd_ok ? r_occ[i_upd_prod_id] : '0;
  assign w_lut_occ     = w_lut_ok ? r_occ[i_lut_prod_id] : '0;
  assign w_lut_lvl_err = CMP_W'(i_lut_level) >= CMP_W'(w_lut_occ);

  assign w_empty = (r_cnt_out == '0);
  assign w_full  = (r_cnt_out == (PTR_W+1)'(MAX_OUT));
  assign w_age   = r_ts - r_fifo[r_rd];
  // a lost lookup is retired by its timeout so it is reported exactly once
  assign w_to    = !w_empty && !i_rsp_vld && (w_age >= TS_W'(TIMEOUT));
  assign w_pop   = (i_rsp_vld && !w_empty) || w_to;
  assign w_ovf   = i_lut_vld && w_lut_ok && w_full && !w_pop;
  assign w_push  = i_lut_vld && w_lut_ok && !w_ovf;

  always_comb begin
    w_err = '0;
    if (i_upd_vld) begin
      if (!w_upd_ok) w_err[0] = 1'b1;
      else begin
        case (i_upd_cmd)
          2'd1:    w_err[1] = (w_upd_occ == OCC_W'(DEPTH));
          2'd2:    w_err[2] = (w_upd_occ == '0);
          2'd3:    w_err[3] = (w_upd_occ == '0);
          default: ;
        endcase
      end
    end
    if (i_lut_vld) begin
      if (!w_lut_ok) w_err[4] = 1'b1;
      else           w_err[5] = w_lut_lvl_err;
    end
    w_err[6] = i_rsp_vld && w_empty;
    w_err[7] = w_to;
    w_err[8] = w_ovf;
    w_code = '0;
    for (int k = 8; k >= 0; k--)
      if (w_err[k]) w_code = 4'(k + 1);
    case (w_code)
      4'd1, 4'd2, 4'd3, 4'd4: w_prod = i_upd_prod_id;
      4'd5, 4'd6, 4'd9:       w_prod = i_lut_prod_id;
      default:                w_prod = '0;
    endcase
  end

  assign w_upd_err = |w_err[3:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_occ         <= '0;
      r_fifo        <= '0;
      r_rd          <= '0;
      r_wr          <= '0;
      r_cnt_out     <= '0;
      r_ts          <= '0;
      o_err_vld     <= 1'b0;
      o_err_code    <= '0;
      o_err_prod_id <= '0;
      o_err_sticky  <= 1'b0;
      o_err_cnt     <= '0;
    end else begin
      r_ts <= r_ts + 1'b1;
      if (i_upd_vld && !w_upd_err) begin
        case (i_upd_cmd)
          2'd0:    r_occ[i_upd_prod_id] <= '0;
          2'd1:    r_occ[i_upd_prod_id] <= w_upd_occ + 1'b1;
          2'd2:    r_occ[i_upd_prod_id] <= w_upd_occ - 1'b1;
          default: ;
        endcase
      end
      if (w_pop) r_rd <= r_rd + 1'b1;
      if (w_push) begin
        r_fifo[r_wr] <= r_ts;
        r_wr         <= r_wr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_cnt_out <= r_cnt_out + 1'b1;
        2'b01:   r_cnt_out <= r_cnt_out - 1'b1;
        default: ;
      endcase
      o_err_vld     <= (w_code != '0);
      o_err_code    <= w_code;
      o_err_prod_id <= w_prod;
      // a coincident error beats a clear
      if (w_code != '0) begin
        o_err_sticky <= 1'b1;
        if (i_err_clr)            o_err_cnt <= ERR_CNT_W'(1);
        else if (o_err_cnt != '1) o_err_cnt <= o_err_cnt + 1'b1;
      end else if (i_err_clr) begin
        o_err_sticky <= 1'b0;
        o_err_cnt    <= '0;
      end
    end
  end

  assign o_occ = r_occ;
endmodule

// File: tb/tb_v_bus_chk.sv
// Scoreboard bench for v_bus_chk: directed protocol scenarios plus random traffic
// compared against a queue-based reference model.
module tb_v_bus_chk;
  localparam int NP = 3, DEPTH = 16, KW = 16, SW = 16, LW = 4, MO = 4, TO = 32, CW = 4;
  localparam int PW = 2, OW = 5, TSM = 64;

  logic clk = 1'b0, rst = 1'b1;
  logic i_upd_vld = 0, i_lut_vld = 0, i_rsp_vld = 0, i_err_clr = 0;
  logic [PW-1:0] i_upd_prod_id = 0, i_lut_prod_id = 0;
  logic [1:0] i_upd_cmd = 0;
  logic [KW-1:0] i_upd_key = 0;
  logic [SW-1:0] i_upd_size = 0;
  logic [LW-1:0] i_lut_level = 0;
  logic o_err_vld, o_err_sticky;
  logic [3:0] o_err_code;
  logic [PW-1:0] o_err_prod_id;
  logic [CW-1:0] o_err_cnt;
  logic [NP*OW-1:0] o_occ;

  v_bus_chk #(.N_PROD(NP), .DEPTH(DEPTH), .KEY_W(KW), .SIZE_W(SW), .LEVEL_W(LW),
              .MAX_OUT(MO), .TIMEOUT(TO), .ERR_CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .i_upd_vld(i_upd_vld), .i_upd_prod_id(i_upd_prod_id), .i_upd_cmd(i_upd_cmd),
    .i_upd_key(i_upd_key), .i_upd_size(i_upd_size),
    .i_lut_vld(i_lut_vld), .i_lut_prod_id(i_lut_prod_id), .i_lut_level(i_lut_level),
    .i_rsp_vld(i_rsp_vld), .i_err_clr(i_err_clr),
    .o_err_vld(o_err_vld), .o_err_code(o_err_code), .o_err_prod_id(o_err_prod_id),
    .o_err_sticky(o_err_sticky), .o_err_cnt(o_err_cnt), .o_occ(o_occ));

  always #5 clk = ~clk;

  typedef struct {
    bit vld; int code; int prod; bit sticky; int cnt; logic [NP*OW-1:0] occ;
  } exp_t;
  exp_t sbq[$];

  int m_occ[NP];
  int m_q[$];
  int m_ts, m_cnt;
  bit m_sticky;
  int checks = 0, failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: applies one cycle of bus activity to abstract state and
  // predicts the registered report visible after the next clock edge.
  task automatic step(input bit r, input bit uv, input int id, input int cmd,
                      input bit lv, input int lid, input int lvl, input bit rs, input bit cl);
    exp_t e;
    bit [9:0] ev;
    bit empty, full, to, pop, ovf;
    int code, prod;
    @(negedge clk);
    rst = r; i_upd_vld = uv; i_upd_prod_id = PW'(id); i_upd_cmd = 2'(cmd);
    i_upd_key = KW'($urandom); i_upd_size = SW'($urandom);
    i_lut_vld = lv; i_lut_prod_id = PW'(lid); i_lut_level = LW'(lvl);
    i_rsp_vld = rs; i_err_clr = cl;
    if (r) begin
      foreach (m_occ[i]) m_occ[i] = 0;
      m_q.delete(); m_ts = 0; m_cnt = 0; m_sticky = 0;
      e = '{0, 0, 0, 0, 0, '0};
      sbq.push_back(e);
      return;
    end
    ev = '0;
    if (uv) begin
      if (id >= NP) ev[1] = 1;
      else if (cmd == 1 && m_occ[id] == DEPTH) ev[2] = 1;
      else if (cmd == 2 && m_occ[id] == 0) ev[3] = 1;
      else if (cmd == 3 && m_occ[id] == 0) ev[4] = 1;
    end
    if (lv) begin
      if (lid >= NP) ev[5] = 1;
      else if (lvl >= m_occ[lid]) ev[6] = 1;
    end
    empty = (m_q.size() == 0);
    full  = (m_q.size() == MO);
    to    = !empty && !rs && (((m_ts - m_q[0]) % TSM + TSM) % TSM >= TO);
    pop   = (rs && !empty) || to;
    ovf   = lv && lid < NP && full && !pop;
    ev[7] = rs && empty;
    ev[8] = to;
    ev[9] = ovf;
    if (pop) void'(m_q.pop_front());
    if (lv && lid < NP && !ovf) m_q.push_back(m_ts);
    if (uv && id < NP && ev[4:1] == 0) begin
      if (cmd == 0) m_occ[id] = 0;
      else if (cmd == 1) m_occ[id]++;
      else if (cmd == 2) m_occ[id]--;
    end
    m_ts = (m_ts + 1) % TSM;
    code = 0;
    for (int k = 9; k >= 1; k--) if (ev[k]) code = k;
    prod = (code >= 1 && code <= 4) ? id : (code == 5 || code == 6 || code == 9) ? lid : 0;
    if (code != 0) begin
      m_sticky = 1;
      m_cnt = cl ? 1 : (m_cnt == (1 << CW) - 1 ? m_cnt : m_cnt + 1);
    end else if (cl) begin
      m_sticky = 0; m_cnt = 0;
    end
    e.vld = (code != 0); e.code = code; e.prod = prod & 3;
    e.sticky = m_sticky; e.cnt = m_cnt;
    for (int i = 0; i < NP; i++) e.occ[i*OW +: OW] = OW'(m_occ[i]);
    sbq.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: each edge presents a new registered report; pop and compare.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("err_vld", int'(o_err_vld), int'(e.vld));
        if (e.vld || o_err_vld) begin
          chk("err_code", int'(o_err_code), e.code);
          chk("err_prod", int'(o_err_prod_id), e.prod);
        end
        chk("err_sticky", int'(o_err_sticky), int'(e.sticky));
        chk("err_cnt", int'(o_err_cnt), e.cnt);
        chk("occ", int'(o_occ), int'(e.occ));
      end
    end
  end

  initial begin
    int x, id, lid, cmd;
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 1, 1, 1, 1, 1, 1, 1);
    // fill product 2 then overflow it
    repeat (17) step(0, 1, 2, 1, 0, 0, 0, 0, 0);
    // DEL_EMPTY and LUT_LEVEL together on product 0
    step(0, 1, 0, 2, 1, 0, 0, 0, 0);
    // lookup sees pre-update occupancy
    step(0, 1, 1, 1, 0, 0, 0, 0, 0);
    step(0, 1, 1, 1, 1, 1, 0, 0, 0);
    idle(1);
    // answer the two pending lookups
    step(0, 0, 0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 0);
    // lost lookup times out, then a stray response
    step(0, 0, 0, 0, 1, 2, 3, 0, 0);
    idle(40);
    step(0, 0, 0, 0, 0, 0, 0, 1, 0);
    // fill FIFO, push while popping, then overflow
    repeat (4) step(0, 0, 0, 0, 1, 2, 0, 0, 0);
    step(0, 0, 0, 0, 1, 2, 0, 1, 0);
    step(0, 0, 0, 0, 1, 2, 0, 0, 0);
    idle(40);
    // out-of-range ids
    step(0, 1, 3, 1, 1, 3, 0, 0, 0);
    step(0, 0, 0, 0, 1, 3, 0, 0, 0);
    // saturate the counter, error-vs-clear, then plain clear
    repeat (20) step(0, 1, 0, 2, 0, 0, 0, 0, 0);
    step(0, 1, 0, 2, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    // reset while a lookup is pending: no timeout afterwards
    step(0, 0, 0, 0, 1, 2, 0, 0, 0);
    idle(10);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(40);
    repeat (3000) begin
      x   = $urandom_range(0, 9);
      cmd = (x < 5) ? 1 : (x < 7) ? 2 : (x < 9) ? 3 : 0;
      id  = ($urandom_range(0, 15) == 0) ? 3 : $urandom_range(0, NP - 1);
      lid = ($urandom_range(0, 15) == 0) ? 3 : $urandom_range(0, NP - 1);
      step($urandom_range(0, 499) == 0, $urandom_range(0, 1) == 1, id, cmd,
           $urandom_range(0, 2) == 0, lid, $urandom_range(0, 7),
           $urandom_range(0, 3) == 0, $urandom_range(0, 49) == 0);
    end
    idle(2);
    repeat (10) if (sbq.size() > 0) @(posedge clk);
    @(negedge clk);
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d entries left, expected 0", sbq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
